// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3 convolution sequencer.
//   state_e       : sequencer FSM states
//   KERNEL_TAPS   : number of kernel weights loaded per frame
//   conv_ow/oh    : output feature-map dimensions for a given stride
// -----------------------------------------------------------------------------
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_K,
      ISSUE,
      WAIT,
      WRITE,
      DONE
   } state_e;

   localparam int KERNEL_TAPS = 9;

   // Valid 3x3 window positions along one axis. A stride of 2 is a right
   // shift of the span, so the floor division comes for free.
   function automatic int conv_out_dim(input int img, input logic stride_2);
      return ((img - 3) >> stride_2) + 1;
   endfunction

   function automatic int conv_ow(input int img_w, input logic stride_2);
      return conv_out_dim(img_w, stride_2);
   endfunction

   function automatic int conv_oh(input int img_h, input logic stride_2);
      return conv_out_dim(img_h, stride_2);
   endfunction

endpackage

// File: rtl/conv_win_counter.sv
// -----------------------------------------------------------------------------
// conv_win_counter
// Output-position counters for the 3x3 window walk.
//   clk_i, rst_ni    : clock, async active-low reset
//   clr_i            : restart at output position (0,0)
//   adv_i            : step to the next output position (row-major)
//   active_i         : window outputs track the counters; otherwise they hold
//   stride_i         : latched stride, 0 = 1, 1 = 2
//   win_row_o/col_o  : top-left pixel of the current window
//   dest_address_o   : linear output index orow*OW + ocol
//   last_o           : current position is the final one of the frame
// -----------------------------------------------------------------------------
module conv_win_counter
   import conv_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              adv_i,
   input  logic              active_i,
   input  logic              stride_i,
   output logic [ADDR_W-1:0] win_row_o,
   output logic [ADDR_W-1:0] win_col_o,
   output logic [ADDR_W-1:0] dest_address_o,
   output logic              last_o
);

   localparam logic [ADDR_W-1:0] COL_MAX_S1 = ADDR_W'(conv_ow(IMG_W, 1'b0) - 1);
   localparam logic [ADDR_W-1:0] COL_MAX_S2 = ADDR_W'(conv_ow(IMG_W, 1'b1) - 1);
   localparam logic [ADDR_W-1:0] ROW_MAX_S1 = ADDR_W'(conv_oh(IMG_H, 1'b0) - 1);
   localparam logic [ADDR_W-1:0] ROW_MAX_S2 = ADDR_W'(conv_oh(IMG_H, 1'b1) - 1);

   logic [ADDR_W-1:0] orow_q, orow_d;
   logic [ADDR_W-1:0] ocol_q, ocol_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [ADDR_W-1:0] row_hold_q, col_hold_q, dest_hold_q;
   logic [ADDR_W-1:0] col_max, row_max, row_cur, col_cur;
   logic              col_last;

   // NOTE: every always_comb output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      col_max  = stride_i ? COL_MAX_S2 : COL_MAX_S1;
      row_max  = stride_i ? ROW_MAX_S2 : ROW_MAX_S1;
      col_last = (ocol_q == col_max);
      last_o   = col_last && (orow_q == row_max);
      row_cur  = orow_q << stride_i;
      col_cur  = ocol_q << stride_i;

      orow_d = orow_q;
      ocol_d = ocol_q;
      dest_d = dest_q;
      if (clr_i) begin
         orow_d = '0;
         ocol_d = '0;
         dest_d = '0;
      end else if (adv_i) begin
         // Row-major walk, so a running count equals orow*OW + ocol.
         dest_d = dest_q + 1'b1;
         if (col_last) begin
            ocol_d = '0;
            orow_d = orow_q + 1'b1;
         end else begin
            ocol_d = ocol_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   // NOTE: the hold registers are reset too, since they drive ports that must
   // read 0 while reset is asserted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         orow_q      <= '0;
         ocol_q      <= '0;
         dest_q      <= '0;
         row_hold_q  <= '0;
         col_hold_q  <= '0;
         dest_hold_q <= '0;
      end else begin
         orow_q <= orow_d;
         ocol_q <= ocol_d;
         dest_q <= dest_d;
         if (active_i) begin
            row_hold_q  <= row_cur;
            col_hold_q  <= col_cur;
            dest_hold_q <= dest_q;
         end
      end
   end

   // Live values while a window is in flight, last captured values otherwise.
   assign win_row_o      = active_i ? row_cur : row_hold_q;
   assign win_col_o      = active_i ? col_cur : col_hold_q;
   assign dest_address_o = active_i ? dest_q  : dest_hold_q;

endmodule

// File: rtl/conv3x3_sched.sv
// -----------------------------------------------------------------------------
// conv3x3_sched
// Sequencer for the 3x3 convolution datapath: loads the kernel weights, then
// walks the window over the feature map and handshakes each window.
//   i_clk, i_rst_n  : clock, async active-low reset
//   start, stride   : frame request and stride select (0 = 1, 1 = 2)
//   conv_done       : datapath result ready (honoured only in WAIT)
//   kern_addr/rd_en : kernel weight fetch
//   win_row/col     : window origin handed to the datapath
//   conv_start      : one-cycle window launch
//   dest_address/wr : destination write
//   busy, done      : frame in progress / one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module conv3x3_sched
   import conv_pkg::*;
#(
   parameter int BIT_DEPTH = 8,
   parameter int IMG_W     = 8,
   parameter int IMG_H     = 8,
   parameter int ADDR_W    = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              start,
   input  logic              stride,
   input  logic              conv_done,
   output logic [3:0]        kern_addr,
   output logic              kern_rd_en,
   output logic [ADDR_W-1:0] win_row,
   output logic [ADDR_W-1:0] win_col,
   output logic              conv_start,
   output logic [ADDR_W-1:0] dest_address,
   output logic              dest_wr_en,
   output logic              busy,
   output logic              done
);

   // A 3x3 window must fit in the map; other configurations stop elaboration.
   if (IMG_W < 3 || IMG_H < 3 || BIT_DEPTH < 1) begin : g_bad_geometry
      $error("conv3x3_sched: unsupported geometry");
   end

   state_e     state_q, state_d;
   logic       stride_q, stride_d;
   logic [3:0] kidx_q, kidx_d;
   logic       cnt_clr, cnt_adv, cnt_active, last_win;

   always_comb begin
      state_d    = state_q;
      stride_d   = stride_q;
      kidx_d     = kidx_q;
      kern_rd_en = 1'b0;
      conv_start = 1'b0;
      dest_wr_en = 1'b0;
      done       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_adv    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               stride_d = stride;
               cnt_clr  = 1'b1;
               state_d  = LOAD_K;
            end
         end
         LOAD_K: begin
            kern_rd_en = 1'b1;
            if (kidx_q == 4'(KERNEL_TAPS - 1)) begin
               kidx_d  = '0;
               state_d = ISSUE;
            end else begin
               kidx_d = kidx_q + 1'b1;
            end
         end
         ISSUE: begin
            conv_start = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (conv_done) state_d = WRITE;
         end
         WRITE: begin
            dest_wr_en = 1'b1;
            cnt_adv    = 1'b1;
            state_d    = last_win ? DONE : ISSUE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         stride_q <= 1'b0;
         kidx_q   <= '0;
      end else begin
         state_q  <= state_d;
         stride_q <= stride_d;
         kidx_q   <= kidx_d;
      end
   end

   assign cnt_active = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WRITE);
   // kidx_q is only nonzero inside LOAD_K, so it can drive the port directly.
   assign kern_addr  = kidx_q;
   assign busy       = (state_q != IDLE);

   conv_win_counter #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_win_counter (
      .clk_i          (i_clk),
      .rst_ni         (i_rst_n),
      .clr_i          (cnt_clr),
      .adv_i          (cnt_adv),
      .active_i       (cnt_active),
      .stride_i       (stride_q),
      .win_row_o      (win_row),
      .win_col_o      (win_col),
      .dest_address_o (dest_address),
      .last_o         (last_win)
   );

endmodule

// File: doc/conv3x3_sched.md
Name: conv3x3_sched

Overview:
- Sequencer for the 3x3 convolution datapath.
- Loads the 9 kernel weights, then walks the 3x3 window across an IMG_H x IMG_W feature map at stride 1 or 2.
- Per window: hands the datapath the window origin, waits for its completion handshake, then issues the destination write.
- Sits between the top-level command interface and the convolve datapath and feature-map memories.

Parameters:
- BIT_DEPTH, 8: pixel/weight width (sizes nothing here; kept for package consistency).
- IMG_W, 8: feature-map width in pixels (>=3).
- IMG_H, 8: feature-map height in pixels (>=3).
- ADDR_W, 8: width of row/col/destination address outputs; must hold max(IMG_W, IMG_H, OW*OH).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- stride  in  1  0 = stride 1, 1 = stride 2; latched when start is accepted.
- conv_done  in  1  datapath result valid; honoured only in WAIT.
- kern_addr  out  4  kernel weight index 0..8.
- kern_rd_en  out  1  kernel read strobe.
- win_row  out  ADDR_W  top row of current window.
- win_col  out  ADDR_W  left column of current window.
- conv_start  out  1  one-cycle pulse: datapath begins a window.
- dest_address  out  ADDR_W  output index = orow*OW + ocol.
- dest_wr_en  out  1  one-cycle destination write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; counters and latched stride cleared. Reset deasserting mid-frame yields IDLE; no partial write, no done.
- Derived output dimensions: OW = (IMG_W-3)/s + 1 and OH = (IMG_H-3)/s + 1, s = 1 or 2, floor division. Defaults give 6x6 at s=1 and 3x3 at s=2.
- IDLE: if start=1, latch stride, go to LOAD_K. start while busy is ignored.
- LOAD_K: 9 cycles; kern_rd_en=1; kern_addr = 0,1,…,8 on consecutive cycles. After kern_addr=8, go to ISSUE.
- ISSUE: 1 cycle; conv_start=1; win_row = orow*s, win_col = ocol*s. Go to WAIT.
- WAIT: win_row and win_col held stable. Stay until conv_done=1 (minimum 1 cycle, no timeout), then go to WRITE.
- WRITE: 1 cycle; dest_wr_en=1; dest_address = orow*OW + ocol.
  - Counter advance in the same cycle: ocol++; when ocol wraps at OW-1, ocol=0 and orow++.
  - If this was the last window (orow=OH-1, ocol=OW-1), go to DONE; else go to ISSUE.
- DONE: 1 cycle; done=1; go to IDLE. start in this cycle is ignored.
- win_row, win_col and dest_address hold their last values outside ISSUE, WAIT and WRITE. Only the strobes (kern_rd_en, conv_start, dest_wr_en, done) return to 0.
- conv_done in any state other than WAIT is ignored.
- Multiplications by s are shifts; OW and OH are elaborated as constants for each stride value.
- Timing, with start high at cycle 0 and conv_done high on the first WAIT cycle:
  - LOAD_K occupies cycles 1–9.
  - First ISSUE at cycle 10.
  - Each window takes 3 cycles.
  - done at cycle 10 + 3·N (N = OW·OH): cycle 118 at s=1 (N=36), cycle 37 at s=2 (N=9).

Decomposition:
- Package conv_pkg holds:
  - state enum: IDLE, LOAD_K, ISSUE, WAIT, WRITE, DONE.
  - KERNEL_TAPS = 9.
  - Constant functions for OW and OH given IMG_W, IMG_H and stride.
- One natural sub-module: conv_win_counter. It holds the orow/ocol counters with wrap and last flag, and produces win_row, win_col and dest_address.
- The FSM stays in conv3x3_sched.

Test Plan:
- Kernel load: reset, pulse start with stride=0 → kern_rd_en high cycles 1–9, kern_addr 0..8 in order, first conv_start at cycle 10.
- Full frame at stride 1, conv_done returned 1 cycle after conv_start:
  - 36 dest_wr_en pulses, dest_address 0..35 in order.
  - win_col sequence 0..5 per row, win_row 0..5.
  - done at cycle 118.
- Full frame at stride 2:
  - 9 writes, dest_address 0..8.
  - (win_row, win_col) ∈ {0,2,4}², row-major.
  - done at cycle 37.
  - Toggling stride mid-frame has no effect.
- Handshake stall: conv_done delayed 5 cycles on window 3 → no dest_wr_en until conv_done; win_row/win_col stable throughout WAIT. Spurious conv_done during LOAD_K causes no write.
- Start while busy: pulse start during WAIT → ignored; exactly one done for the frame.
- Reset mid-operation: assert i_rst_n=0 during WAIT of window 10 → all outputs 0 immediately; after release, the block stays IDLE until a new start.
